// File: rtl/ram_pkg.sv
// Shared definitions for the RAM responder slice: FSM state encoding,
// default geometry and the wait-state ceiling.
package ram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = 4;

  // FSM state encoding, also visible on the debug state output
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/ram_array.sv
// Word storage with one synchronous port. A write stores wrData; a read
// registers the addressed word into rdData, which keeps its value until the
// next read. Only the read register is reset, never the storage itself.
module ram_array
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wrData,
  output logic [WORD_W-1:0] rdData
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Commit a write when the port is enabled for writing
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wrData;
  end

  // Capture the addressed word on an enabled read; hold it otherwise
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)          rdData <= '0;
    else if (en && !we) rdData <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// RAM bus responder: latches one request in IDLE, waits WAIT_CYCLES wait
// states, performs the access on entry to ACK (one-cycle READY pulse), then
// parks in HOLD until the requester drops CE so a held request is served once.
// Handshake: a request is taken when iRAM_CE=1 in IDLE; all requester inputs
// are ignored outside IDLE; oRAM_READY pulses for exactly one cycle and
// oRAM_ERR is meaningful only while oRAM_READY=1.
// Optional build macro RAM_PARITY_EN: adds a stored even-parity bit per word,
// the iPAR_INJ fault-injection input and parity checking on reads.
module ram_responder
  import ram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iRAM_CE,
  input  logic              iRAM_RD,
  input  logic              iRAM_WR,
  input  logic [ADDR_W-1:0] iRAM_ADDR,
  input  logic [DATA_W-1:0] iRAM_DATA_WR,
`ifdef RAM_PARITY_EN
  input  logic              iPAR_INJ,
`endif
  output logic [DATA_W-1:0] oRAM_DATA_RD,
  output logic              oRAM_READY,
  output logic              oRAM_ERR,
  output logic [1:0]        oDbgState
);

`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  // Wait states beyond the counter range are clamped to the maximum
  localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_EFF);

  logic [1:0]        state;
  logic [CNT_W-1:0]  waitCnt;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic              latRd;
  logic              latWr;
  logic              latInj;
  logic              inInj;

  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curData;
  logic              curRd;
  logic              curWr;
  logic              curInj;
  logic              enterAck;
  logic              arrEn;
  logic [WORD_W-1:0] wrWord;
  logic [WORD_W-1:0] rdWord;
  logic              parErr;

`ifdef RAM_PARITY_EN
  assign inInj  = iPAR_INJ;
  assign wrWord = {(^curData) ^ curInj, curData};
  assign parErr = ^rdWord;
`else
  assign inInj  = 1'b0;
  assign wrWord = curData;
  assign parErr = 1'b0;
`endif

  // Select the operation being performed: live inputs when ACK is entered
  // straight from IDLE (zero wait states), latched copy otherwise
  always_comb begin
    curAddr  = latAddr;
    curData  = latData;
    curRd    = latRd;
    curWr    = latWr;
    curInj   = latInj;
    enterAck = 1'b0;
    if (state == ST_IDLE) begin
      curAddr  = iRAM_ADDR;
      curData  = iRAM_DATA_WR;
      curRd    = iRAM_RD;
      curWr    = iRAM_WR;
      curInj   = inInj;
      enterAck = iRAM_CE && (WAIT_LD == '0);
    end else if (state == ST_WAIT) begin
      enterAck = (waitCnt <= CNT_W'(1));
    end
    arrEn = enterAck && (curRd ^ curWr);
  end

  // Request latch, wait counter and state sequencing
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
      latAddr <= '0;
      latData <= '0;
      latRd   <= 1'b0;
      latWr   <= 1'b0;
      latInj  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iRAM_CE) begin
            latAddr <= iRAM_ADDR;
            latData <= iRAM_DATA_WR;
            latRd   <= iRAM_RD;
            latWr   <= iRAM_WR;
            latInj  <= inInj;
            if (WAIT_LD == '0) begin
              state <= ST_ACK;
            end else begin
              state   <= ST_WAIT;
              waitCnt <= WAIT_LD;
            end
          end
        end
        ST_WAIT: begin
          waitCnt <= waitCnt - 1'b1;
          if (enterAck) state <= ST_ACK;
        end
        ST_ACK:  state <= ST_HOLD;
        default: if (!iRAM_CE) state <= ST_IDLE;
      endcase
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) uArray (
    .clk    (iCLK),
    .rstN   (iRST_N),
    .en     (arrEn),
    .we     (curWr),
    .addr   (curAddr),
    .wrData (wrWord),
    .rdData (rdWord)
  );

  assign oRAM_DATA_RD = rdWord[DATA_W-1:0];
  assign oRAM_READY   = (state == ST_ACK);
  assign oRAM_ERR     = (state == ST_ACK) && ((latRd == latWr) || (latRd && parErr));
  assign oDbgState    = state;

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait states before acknowledge; legal range is 0..15.
REQ-004 SHALL have port iCLK, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port iRST_N, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port iRAM_CE, input, 1 bit, request valid from the RAM bus mux.
REQ-007 SHALL have ports iRAM_RD and iRAM_WR, input, 1 bit each, operation select.
REQ-008 SHALL have port iRAM_ADDR, input, ADDR_W bits, word address.
REQ-009 SHALL have port iRAM_DATA_WR, input, DATA_W bits, write data.
REQ-010 SHALL have port oRAM_DATA_RD, output, DATA_W bits, read data to the mux.
REQ-011 SHALL have port oRAM_READY, output, 1 bit, one-cycle completion pulse.
REQ-012 SHALL have port oRAM_ERR, output, 1 bit, error flag, valid only with oRAM_READY.
REQ-013 SHALL have port iPAR_INJ, input, 1 bit, parity-fault injection; present only with RAM_PARITY_EN.

Function
REQ-014 SHALL implement a 2**ADDR_W x DATA_W word array.
REQ-015 SHALL run the FSM states IDLE, WAIT, ACK and HOLD.
REQ-016 IDLE with iRAM_CE=1 SHALL latch ADDR, DATA_WR, RD and WR, then go to WAIT loaded with WAIT_CYCLES, or directly to ACK when WAIT_CYCLES=0.
REQ-017 WAIT SHALL decrement the counter each cycle and go to ACK in the cycle after it reaches 0; request-to-READY latency is WAIT_CYCLES+1 cycles.
REQ-018 On entering ACK, a latched write SHALL commit to the array and a latched read SHALL register the array word into oRAM_DATA_RD.
REQ-019 oRAM_READY SHALL be 1 exactly for the ACK cycle.
REQ-020 After ACK the FSM SHALL go to HOLD and remain there while iRAM_CE=1, returning to IDLE once iRAM_CE=0, so that a held request is served exactly once.
REQ-021 With latched RD=WR=1 or RD=WR=0, the block SHALL leave the array and oRAM_DATA_RD unchanged and assert oRAM_ERR=1 with READY.
REQ-022 Requester inputs SHALL be ignored outside IDLE; deasserting iRAM_CE during WAIT SHALL NOT abort the latched operation.
REQ-023 oRAM_DATA_RD SHALL hold the last successful read value until the next read completes, and SHALL be unaffected by writes.
REQ-024 A read of an address written by the previous operation SHALL return the new data.

Reset
REQ-025 iRST_N=0 SHALL force IDLE, counter 0, oRAM_READY=0, oRAM_ERR=0 and oRAM_DATA_RD=0 asynchronously.
REQ-026 Array contents SHALL NOT be reset.
REQ-027 A reset during WAIT SHALL discard the pending operation, and no write SHALL commit.

Configuration
REQ-028 Macro RAM_PARITY_EN defined SHALL store an even-parity bit per word, computed as the XOR of the write data and inverted when iPAR_INJ=1 at latch time.
REQ-029 With RAM_PARITY_EN defined, a read with a parity mismatch SHALL still return the data and assert oRAM_ERR=1 with READY.
REQ-030 With RAM_PARITY_EN undefined, there SHALL be no parity storage and no iPAR_INJ port, and oRAM_ERR SHALL flag only the illegal operations in REQ-021.

Structure
REQ-031 Package ram_pkg SHALL hold the FSM state encoding, default ADDR_W/DATA_W and the WAIT_CYCLES maximum.
REQ-032 Storage SHALL be a sub-module ram_array with a single synchronous write/read port; the FSM and handshake SHALL stay in ram_responder.

Verification
REQ-033 Write 0xDEADBEEF to addr 0x10 then read addr 0x10 (WAIT_CYCLES=1) -> READY 2 cycles after each CE rise; DATA_RD=0xDEADBEEF, ERR=0.
REQ-034 Hold CE=1,RD=1 for 10 cycles -> exactly one READY pulse; FSM stays in HOLD until CE falls.
REQ-035 CE=1 with RD=1,WR=1 at addr 0x20 -> READY with ERR=1; a later read of 0x20 returns its prior value.
REQ-036 Assert iRST_N=0 during WAIT of a write of 0x12345678 to 0x30 -> outputs 0 immediately; a later read of 0x30 does not return 0x12345678.
REQ-037 WAIT_CYCLES=0, write then read addr 0xFF -> READY 1 cycle after each CE rise; DATA_RD matches.
REQ-038 With RAM_PARITY_EN defined, write 0x1 to 0x40 with iPAR_INJ=1, then read -> DATA_RD=0x1 and ERR=1; without iPAR_INJ -> ERR=0.
